// File: rtl/bel_fft_sif_pkg.sv
// Shared definitions for the FFT slave-interface front-end: default widths,
// response codes, the error data pattern and the request FSM encoding.
package bel_fft_sif_pkg;

  localparam int SIF_AWIDTH = 8;
  localparam int SIF_DWIDTH = 32;

  // Avalon response codes returned alongside read data
  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b10;

  // Data returned for errored / timed-out reads when no response port exists
  localparam logic [31:0] SIF_ERR_PAT = 32'hDEADBEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } sif_state_e;

endpackage

// File: rtl/bel_fft_sif_rsp_fifo.sv
// Small synchronous FIFO holding read responses. The head word is always
// visible on dout (first-word-fall-through); pop advances it.
module bel_fft_sif_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  // storage array needs no reset; only pointers define validity
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= din;
  end

  // pointer and occupancy tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bel_fft_avl_sif_pipe.sv
// Avalon-MM slave front-end for the FFT register/buffer interface.
// Registers each accepted request, holds a single outstanding strobe to the
// internal target until ack/err/timeout, and queues read responses so that
// readdatavalid is produced in order, one per accepted read.
// Optional build macro BEL_FFT_SIF_RESP_EN adds a 2-bit response output and
// returns real target data on errored reads instead of the error pattern.
module bel_fft_avl_sif_pipe
  import bel_fft_sif_pkg::*;
#(
  parameter int AWIDTH    = SIF_AWIDTH,
  parameter int DWIDTH    = SIF_DWIDTH,
  parameter int BCNT      = DWIDTH/8,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AWIDTH-1:0] address,
  input  logic [DWIDTH-1:0] writedata,
  input  logic              read,
  input  logic              write,
  input  logic [BCNT-1:0]   byteenable,
  output logic              waitrequest,
  output logic [DWIDTH-1:0] readdata,
  output logic              readdatavalid,
`ifdef BEL_FFT_SIF_RESP_EN
  output logic [1:0]        response,
`endif
  output logic [AWIDTH-1:0] adr_o,
  output logic [DWIDTH-1:0] dat_o,
  output logic [BCNT-1:0]   bsel_o,
  output logic              wr_o,
  output logic              rd_o,
  input  logic [DWIDTH-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i
);

  localparam int CW  = $clog2(RSP_DEPTH+1);
  localparam int FCW = $clog2(RSP_DEPTH)+1;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);
`ifdef BEL_FFT_SIF_RESP_EN
  localparam int FW = DWIDTH + 2;
`else
  localparam int FW = DWIDTH;
`endif

  sif_state_e     state, state_nxt;
  logic [CW-1:0]  credit;
  logic [TW-1:0]  tcnt;
  logic           acc, acc_rd, tmo, done, is_err;
  logic           fifo_push, fifo_pop, fifo_empty;
  logic [FW-1:0]  fifo_din, fifo_dout;
  logic [FCW-1:0] fifo_cnt;

  // Write wins when read and write are both asserted
  assign acc    = (read || write) && !waitrequest;
  assign acc_rd = acc && !write;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (acc)  state_nxt = ST_BUSY;
      ST_BUSY: if (done) state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: stall and completion decode (ack/err ignored while idle)
  always_comb begin
    waitrequest = rst_i || (state == ST_BUSY) || (read && (credit == '0));
    tmo         = 1'b0;
    done        = 1'b0;
    is_err      = 1'b0;
    if (state == ST_BUSY) begin
      tmo    = (TIMEOUT != 0) && (tcnt == TLAST);
      done   = ack_i || err_i || tmo;
      is_err = err_i || tmo;
    end
  end

  // request register and held strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_o  <= '0;
      dat_o  <= '0;
      bsel_o <= '0;
      wr_o   <= 1'b0;
      rd_o   <= 1'b0;
    end else if (acc) begin
      adr_o  <= address;
      dat_o  <= writedata;
      bsel_o <= byteenable;
      wr_o   <= write;
      rd_o   <= !write;
    end else if (done) begin
      wr_o   <= 1'b0;
      rd_o   <= 1'b0;
    end
  end

  // timeout counter runs only while a transfer is outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          tcnt <= '0;
    else if (state == ST_BUSY && !done) tcnt <= tcnt + TW'(1);
    else                                tcnt <= '0;
  end

  // read credits: taken on read accept, returned when the response leaves the FIFO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) credit <= CW'(RSP_DEPTH);
    else begin
      case ({acc_rd, fifo_pop})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  // Credits already bound the push rate; the full check is a backstop only
  assign fifo_push = done && rd_o && (fifo_cnt != FCW'(RSP_DEPTH));
  assign fifo_pop  = !fifo_empty;

`ifdef BEL_FFT_SIF_RESP_EN
  assign fifo_din = {(is_err ? RSP_SLVERR : RSP_OKAY), dat_i};
`else
  assign fifo_din = is_err ? DWIDTH'(SIF_ERR_PAT) : dat_i;
`endif

  bel_fft_sif_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // response output register: one FIFO entry drains per cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      readdatavalid <= 1'b0;
      readdata      <= '0;
`ifdef BEL_FFT_SIF_RESP_EN
      response      <= RSP_OKAY;
`endif
    end else begin
      readdatavalid <= fifo_pop;
      if (fifo_pop) begin
        readdata <= fifo_dout[DWIDTH-1:0];
`ifdef BEL_FFT_SIF_RESP_EN
        response <= fifo_dout[FW-1:DWIDTH];
`endif
      end
    end
  end

endmodule
